axi4_slice: RTL



---
 rtl/axi4_slice_pkg.sv | 49 ++++
 rtl/axi4_chan_fifo.sv | 82 ++++++++
 rtl/axi4_slice.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/axi4_slice_pkg.sv
// axi4_slice_pkg
// Shared widths and field positions for the AXI4 channel slice.
// Payload widths are computed from the per-instance parameters, so one
// design can host several AXI4 flavours side by side.
// Field offsets for AW/AR are measured from the top of the user field,
// i.e. bit (USER_W + OFF) is the LSB of that field in the packed payload.
// Optional feature macro (used by axi4_slice): AXI4_SLICE_USER_EN.

package axi4_slice_pkg;

    localparam int ARLEN_W      = 8;
    localparam int AX_SIZE_W    = 3;
    localparam int AX_BURST_W   = 2;
    localparam int AX_LOCK_W    = 1;
    localparam int AX_CACHE_W   = 4;
    localparam int AX_PROT_W    = 3;
    localparam int AX_QOS_W     = 4;
    localparam int AX_REGION_W  = 4;
    localparam int AX_FIXED_W   = 29;

    localparam int AX_REGION_OFF = 0;
    localparam int AX_QOS_OFF    = 4;
    localparam int AX_PROT_OFF   = 8;
    localparam int AX_CACHE_OFF  = 11;
    localparam int AX_LOCK_OFF   = 15;
    localparam int AX_BURST_OFF  = 16;
    localparam int AX_SIZE_OFF   = 18;
    localparam int AX_LEN_OFF    = 21;

    localparam int RESP_W = 2;

    // AW and AR share the same packing.
    function automatic int aw_w(input int id_w, input int addr_w, input int user_w);
        return id_w + addr_w + AX_FIXED_W + user_w;
    endfunction

    function automatic int w_w(input int data_w, input int user_w);
        return data_w + data_w / 8 + 1 + user_w;
    endfunction

    function automatic int b_w(input int id_w, input int user_w);
        return id_w + RESP_W + user_w;
    endfunction

    function automatic int r_w(input int id_w, input int data_w, input int user_w);
        return id_w + data_w + RESP_W + 1 + user_w;
    endfunction

endpackage

// File: rtl/axi4_chan_fifo.sv
// axi4_chan_fifo
// One AXI4 channel buffer. DEPTH = 0 is a pure wire-through; DEPTH >= 2
// (power of two) is a circular buffer with registered ready and a
// registered read path, so nothing on the s side reaches the m side
// combinationally.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   s_valid_i/s_ready_o/s_data_i   upstream handshake and payload
//   m_valid_o/m_ready_i/m_data_o   downstream handshake and payload
//   cnt_o                   occupancy (0 in bypass)

module axi4_chan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [WIDTH-1:0]         s_data_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [WIDTH-1:0]         m_data_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;

            assign m_valid_o = s_valid_i;
            assign s_ready_o = m_ready_i;
            assign m_data_o  = s_data_i;
            assign cnt_o     = '0;
        end else begin : g_fifo
            localparam int IW = $clog2(DEPTH);
            localparam int PW = IW + 1;

            logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
            logic             ready_q;
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic             empty, full_d, push, pop;

            assign empty = (wr_q == rd_q);
            assign push  = s_valid_i & ready_q;
            assign pop   = ~empty & m_ready_i;
            assign wr_d  = wr_q + PW'(push);
            assign rd_d  = rd_q + PW'(pop);
            // Full when the pointers differ only in the wrap bit; ready is
            // registered from the next-state view so it drops the cycle after
            // the filling push and rises the cycle after the first pop.
            assign full_d = ((wr_d ^ rd_d) == {1'b1, {IW{1'b0}}});

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wr_q    <= '0;
                    rd_q    <= '0;
                    ready_q <= 1'b0;
                end else begin
                    wr_q    <= wr_d;
                    rd_q    <= rd_d;
                    ready_q <= ~full_d;
                end
            end

            always_ff @(posedge clk_i) begin
                if (push) begin
                    mem_q[wr_q[IW-1:0]] <= s_data_i;
                end
            end

            assign s_ready_o = ready_q;
            assign m_valid_o = ~empty;
            // Gate with empty so the payload reads 0 out of reset and between
            // bursts instead of exposing stale storage.
            assign m_data_o  = empty ? '0 : mem_q[rd_q[IW-1:0]];
            assign cnt_o     = wr_q - rd_q;
        end
    endgenerate

endmodule

// File: rtl/axi4_slice.sv
// axi4_slice
// Five independent AXI4 channel buffers between a master (s_ ports) and a
// slave (m_ ports). Each channel depth is a parameter: 0 = bypass,
// otherwise a registered FIFO. B and R flow from m_ to s_.
// Ports:
//   aclk, areset                         clock, synchronous active-high reset
//   s_{aw,w,ar}_valid/ready/payload      from master (in/out/in)
//   s_{b,r}_valid/ready/payload          to master   (out/in/out)
//   m_{aw,w,ar}_valid/ready/payload      to slave    (out/in/out)
//   m_{b,r}_valid/ready/payload          from slave  (in/out/in)
//   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt  per-channel occupancy
// Optional feature macro: AXI4_SLICE_USER_EN. When undefined, the user field
// (always the LSBs of every payload) is not stored and outputs drive it 0.

module axi4_slice
    import axi4_slice_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int USER_W   = 1,
    parameter int AW_DEPTH = 2,
    parameter int W_DEPTH  = 2,
    parameter int B_DEPTH  = 2,
    parameter int AR_DEPTH = 2,
    parameter int R_DEPTH  = 2,
    localparam int AW_W    = aw_w(ID_W, ADDR_W, USER_W),
    localparam int W_W     = w_w(DATA_W, USER_W),
    localparam int B_W     = b_w(ID_W, USER_W),
    localparam int R_W     = r_w(ID_W, DATA_W, USER_W)
) (
    input  logic                       aclk,
    input  logic                       areset,

    input  logic                       s_aw_valid,
    output logic                       s_aw_ready,
    input  logic [AW_W-1:0]            s_aw_payload,
    input  logic                       s_w_valid,
    output logic                       s_w_ready,
    input  logic [W_W-1:0]             s_w_payload,
    output logic                       s_b_valid,
    input  logic                       s_b_ready,
    output logic [B_W-1:0]             s_b_payload,
    input  logic                       s_ar_valid,
    output logic                       s_ar_ready,
    input  logic [AW_W-1:0]            s_ar_payload,
    output logic                       s_r_valid,
    input  logic                       s_r_ready,
    output logic [R_W-1:0]             s_r_payload,

    output logic                       m_aw_valid,
    input  logic                       m_aw_ready,
    output logic [AW_W-1:0]            m_aw_payload,
    output logic                       m_w_valid,
    input  logic                       m_w_ready,
    output logic [W_W-1:0]             m_w_payload,
    input  logic                       m_b_valid,
    output logic                       m_b_ready,
    input  logic [B_W-1:0]             m_b_payload,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [AW_W-1:0]            m_ar_payload,
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [R_W-1:0]             m_r_payload,

    output logic [$clog2(AW_DEPTH):0]  aw_cnt,
    output logic [$clog2(W_DEPTH):0]   w_cnt,
    output logic [$clog2(B_DEPTH):0]   b_cnt,
    output logic [$clog2(AR_DEPTH):0]  ar_cnt,
    output logic [$clog2(R_DEPTH):0]   r_cnt
);

`ifdef AXI4_SLICE_USER_EN
    localparam int STRIP = 0;
`else
    localparam int STRIP = USER_W;
`endif

    localparam int AWS = AW_W - STRIP;
    localparam int WS  = W_W - STRIP;
    localparam int BS  = B_W - STRIP;
    localparam int RS  = R_W - STRIP;

    logic [AWS-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [WS-1:0]  w_in, w_out;
    logic [BS-1:0]  b_in, b_out;
    logic [RS-1:0]  r_in, r_out;

    // User sits in the LSBs, so dropping it is a right shift on the way in
    // and a left shift (zero fill) on the way out; with STRIP = 0 both are
    // plain wires.
    assign aw_in = AWS'(s_aw_payload >> STRIP);
    assign w_in  = WS'(s_w_payload >> STRIP);
    assign b_in  = BS'(m_b_payload >> STRIP);
    assign ar_in = AWS'(s_ar_payload >> STRIP);
    assign r_in  = RS'(m_r_payload >> STRIP);

    assign m_aw_payload = AW_W'(aw_out) << STRIP;
    assign m_w_payload  = W_W'(w_out) << STRIP;
    assign s_b_payload  = B_W'(b_out) << STRIP;
    assign m_ar_payload = AW_W'(ar_out) << STRIP;
    assign s_r_payload  = R_W'(r_out) << STRIP;

    axi4_chan_fifo #(.WIDTH(AWS), .DEPTH(AW_DEPTH)) u_aw (
        .clk_i(aclk), .rst_i(areset),
        .s_valid_i(s_aw_valid), .s_ready_o(s_aw_ready), .s_data_i(aw_in),
        .m_valid_o(m_aw_valid), .m_ready_i(m_aw_ready), .m_data_o(aw_out),
        .cnt_o(aw_cnt)
    );

    axi4_chan_fifo #(.WIDTH(WS), .DEPTH(W_DEPTH)) u_w (
        .clk_i(aclk), .rst_i(areset),
        .s_valid_i(s_w_valid), .s_ready_o(s_w_ready), .s_data_i(w_in),
        .m_valid_o(m_w_valid), .m_ready_i(m_w_ready), .m_data_o(w_out),
        .cnt_o(w_cnt)
    );

    axi4_chan_fifo #(.WIDTH(BS), .DEPTH(B_DEPTH)) u_b (
        .clk_i(aclk), .rst_i(areset),
        .s_valid_i(m_b_valid), .s_ready_o(m_b_ready), .s_data_i(b_in),
        .m_valid_o(s_b_valid), .m_ready_i(s_b_ready), .m_data_o(b_out),
        .cnt_o(b_cnt)
    );

    axi4_chan_fifo #(.WIDTH(AWS), .DEPTH(AR_DEPTH)) u_ar (
        .clk_i(aclk), .rst_i(areset),
        .s_valid_i(s_ar_valid), .s_ready_o(s_ar_ready), .s_data_i(ar_in),
        .m_valid_o(m_ar_valid), .m_ready_i(m_ar_ready), .m_data_o(ar_out),
        .cnt_o(ar_cnt)
    );

    axi4_chan_fifo #(.WIDTH(RS), .DEPTH(R_DEPTH)) u_r (
        .clk_i(aclk), .rst_i(areset),
        .s_valid_i(m_r_valid), .s_ready_o(m_r_ready), .s_data_i(r_in),
        .m_valid_o(s_r_valid), .m_ready_i(s_r_ready), .m_data_o(r_out),
        .cnt_o(r_cnt)
    );

endmodule
